// File: rtl/keypad_entry_encoder.sv
// keypad_entry_encoder
// Turns a raw, bouncing enter button and 4-bit digit switches into clean
// single-cycle entry pulses. Each pulse carries a latched digit. The block
// also tracks the position within an NUM_DIGITS-long code.
//
// Optional feature, enabled by defining ENTRY_TIMEOUT_EN: a partly entered
// code is abandoned after TIMEOUT_CYCLES idle cycles.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   button_i       raw enter button, active-high, asynchronous
//   digit_sw_i     raw digit switches, asynchronous, quasi-static
//   clear_i        synchronous clear of the code position
//   entry_o        one-cycle pulse per accepted press
//   digit_o        digit captured with the latest entry_o
//   digit_index_o  index of the digit the next press will fill
//   last_digit_o   pulse with entry_o when the filled index was NUM_DIGITS-1
//   timeout_o      one-cycle pulse on idle timeout (0 without ENTRY_TIMEOUT_EN)
//
// state      | meaning
// IDLE       | button released and stable
// PRESS_DB   | button seen high, counting stable high samples
// HELD       | press accepted, waiting for release
// RELEASE_DB | button seen low, counting stable low samples
module keypad_entry_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned NUM_DIGITS      = 6,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          button_i,
  input  logic [3:0]                    digit_sw_i,
  input  logic                          clear_i,
  output logic                          entry_o,
  output logic [3:0]                    digit_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_index_o,
  output logic                          last_digit_o,
  output logic                          timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             timeout_hit;

  logic             btn_q1, btn_s;
  logic [3:0]       dig_q1, dig_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q1 <= 1'b0;
      btn_s  <= 1'b0;
      dig_q1 <= 4'h0;
      dig_s  <= 4'h0;
    end else begin
      btn_q1 <= button_i;
      btn_s  <= btn_q1;
      dig_q1 <= digit_sw_i;
      dig_s  <= dig_q1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle that leaves IDLE/HELD already counts as the first stable sample,
  // which is why the counter is loaded with 1 on entry to a debounce state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_DB;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_DB;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // An accept always produces a pulse. A clear in the same cycle still resets
  // the position and suppresses last_digit_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_o       <= 1'b0;
      digit_o       <= 4'h0;
      digit_index_o <= '0;
      last_digit_o  <= 1'b0;
    end else begin
      entry_o      <= accept;
      last_digit_o <= 1'b0;
      if (accept) begin
        digit_o <= dig_s;
        if (clear_i) begin
          digit_index_o <= '0;
        end else if (digit_index_o == IDX_LAST) begin
          digit_index_o <= '0;
          last_digit_o  <= 1'b1;
        end else begin
          digit_index_o <= digit_index_o + IDX_W'(1);
        end
      end else if (clear_i || timeout_hit) begin
        digit_index_o <= '0;
      end
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] idle_q;

  // An entry or a clear in the same cycle takes precedence over the timeout.
  assign timeout_hit = !accept && !clear_i && (digit_index_o != '0) &&
                       (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= timeout_hit;
      if (accept || clear_i || timeout_hit) begin
        idle_q <= '0;
      end else if (digit_index_o != '0) begin
        idle_q <= idle_q + TO_W'(1);
      end
    end
  end
`else
  // TIMEOUT_CYCLES only has a meaning when the timeout is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry_encoder.sv
// Testbench for keypad_entry_encoder (DEBOUNCE_CYCLES=4, NUM_DIGITS=6,
// TIMEOUT_CYCLES=50). The reference model treats the debouncer as a stable
// level plus a run length of disagreeing synchronized samples.
module tb_keypad_entry_encoder;
  localparam int D = 4;
  localparam int N = 6;
  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       entry, last, timeout;
  logic [3:0] digit;
  logic [2:0] idx;

  keypad_entry_encoder #(
    .DEBOUNCE_CYCLES(D),
    .NUM_DIGITS(N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .button_i(button),
    .digit_sw_i(sw),
    .clear_i(clear),
    .entry_o(entry),
    .digit_o(digit),
    .digit_index_o(idx),
    .last_digit_o(last),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int entries = 0;
  int lasts = 0;
  int timeouts = 0;
  int tick_no = 0;
  int first_entry = -1;

  // reference model state
  bit         m_b1, m_b2, m_level;
  int         m_run;
  logic [3:0] m_d1, m_d2, m_digit;
  bit         m_entry, m_last, m_to;
  int         m_idx, m_idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_b1 = 0; m_b2 = 0; m_level = 0; m_run = 0;
    m_d1 = 4'h0; m_d2 = 4'h0; m_digit = 4'h0;
    m_entry = 0; m_last = 0; m_to = 0;
    m_idx = 0; m_idle = 0;
  endtask

  // One clock edge of the reference model, using the inputs present before it.
  task automatic model_step(input bit b, input logic [3:0] s, input bit c);
    bit acc;
    acc = 0;
    if (m_b2 != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = m_b2;
        m_run = 0;
        acc = m_level;
      end
    end else begin
      m_run = 0;
    end
    m_entry = acc;
    m_last = 0;
    m_to = 0;
    if (acc) begin
      m_digit = m_d2;
      m_idle = 0;
      if (c) m_idx = 0;
      else if (m_idx == N - 1) begin
        m_idx = 0;
        m_last = 1;
      end else m_idx++;
    end else if (c) begin
      m_idx = 0;
      m_idle = 0;
    end
`ifdef ENTRY_TIMEOUT_EN
    else if (m_idx != 0) begin
      if (m_idle == T - 1) begin
        m_to = 1;
        m_idx = 0;
        m_idle = 0;
      end else m_idle++;
    end
`endif
    m_b2 = m_b1; m_b1 = b;
    m_d2 = m_d1; m_d1 = s;
  endtask

  task automatic tick(input bit b, input logic [3:0] s, input bit c);
    button = b; sw = s; clear = c;
    @(posedge clk);
    model_step(b, s, c);
    #1;
    tick_no++;
    if (entry === 1'b1) begin
      entries++;
      if (first_entry < 0) first_entry = tick_no;
    end
    if (last === 1'b1) lasts++;
    if (timeout === 1'b1) timeouts++;
    chk("entry", entry, m_entry);
    chk("digit", digit, m_digit);
    chk("index", idx, m_idx);
    chk("last", last, m_last);
    chk("timeout", timeout, m_to);
  endtask

  task automatic press(input logic [3:0] s, input int hi, input int lo);
    repeat (hi) tick(1'b1, s, 1'b0);
    repeat (lo) tick(1'b0, s, 1'b0);
  endtask

  task automatic do_reset(input bit hold_btn);
    rst_n = 1'b0; button = hold_btn; clear = 1'b0;
    #2;
    model_reset();
    chk("rst_entry", entry, 0);
    chk("rst_digit", digit, 0);
    chk("rst_index", idx, 0);
    chk("rst_last", last, 0);
    chk("rst_timeout", timeout, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick_no = 0;
    first_entry = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, l0, t0, len;
    bit lvl;
    logic [3:0] s;

    model_reset();
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // steady press, latency and first digit
    press(4'h7, 10, 8);
    chk("latency", first_entry, 2 + D);
    chk("first_entries", entries, 1);
    chk("first_digit", digit, 7);
    chk("first_index", idx, 1);

    // bounce shorter than the debounce window
    e0 = entries;
    tick(1, 4'h3, 0); tick(1, 4'h3, 0); tick(0, 4'h3, 0);
    tick(1, 4'h3, 0); tick(1, 4'h3, 0);
    repeat (8) tick(0, 4'h3, 0);
    chk("bounce_entries", entries - e0, 0);

    // full code of six digits
    do_reset(1'b0);
    e0 = entries; l0 = lasts;
    for (int k = 1; k <= 6; k++) begin
      press(4'(k), 6, 8);
      chk("code_index", idx, k % N);
      chk("code_digit", digit, k);
    end
    chk("code_entries", entries - e0, 6);
    chk("code_lasts", lasts - l0, 1);

    // long hold with a release bounce
    e0 = entries;
    repeat (100) tick(1, 4'h2, 0);
    tick(0, 4'h2, 0); tick(0, 4'h2, 0); tick(1, 4'h2, 0);
    repeat (10) tick(0, 4'h2, 0);
    chk("hold_entries", entries - e0, 1);

    // clear after two presses, then clear coincident with accept
    tick(0, 4'h0, 1);
    press(4'h9, 6, 8);
    press(4'hA, 6, 8);
    chk("two_index", idx, 2);
    tick(0, 4'h5, 1);
    chk("clear_index", idx, 0);
    chk("clear_digit", digit, 4'hA);
    for (int k = 0; k < 5; k++) press(4'(k + 1), 6, 8);
    chk("five_index", idx, 5);
    repeat (5) tick(1, 4'hC, 0);
    tick(1, 4'hC, 1);
    chk("clracc_entry", entry, 1);
    chk("clracc_last", last, 0);
    chk("clracc_index", idx, 0);
    repeat (8) tick(0, 4'hC, 0);

    // idle timeout
    t0 = timeouts;
    press(4'h4, 6, 60);
`ifdef ENTRY_TIMEOUT_EN
    chk("timeout_pulses", timeouts - t0, 1);
    chk("timeout_index", idx, 0);
`else
    chk("timeout_pulses", timeouts - t0, 0);
    chk("timeout_index", idx, 1);
`endif

    // reset in the middle of a press debounce, button still held
    repeat (3) tick(1, 4'h8, 0);
    e0 = entries;
    do_reset(1'b1);
    repeat (10) tick(1, 4'h8, 0);
    repeat (8) tick(0, 4'h8, 0);
    chk("rstmid_entries", entries - e0, 1);
    chk("rstmid_latency", first_entry, 2 + D);

    // randomized runs against the model
    for (int r = 0; r < 300; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      s = 4'($urandom_range(0, 15));
      for (int j = 0; j < len; j++)
        tick(lvl, s, ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
